// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   WORD          datapath width
//   OFFSET_SHIFT  byte-to-word shift applied to branch/jump offsets
//   RESET_PC_DEF  default text-segment entry point
//   HALT_PC_DEF   default end-of-program marker address
//   pc_state_e    sequencer states BOOT / RUN / HALT
//   low_bits_set  true when an address is not word aligned
package pc_pkg;

  localparam int WORD         = 32;
  localparam int OFFSET_SHIFT = 2;

  localparam logic [WORD-1:0] RESET_PC_DEF = 32'h0040_0020;
  localparam logic [WORD-1:0] HALT_PC_DEF  = 32'h0040_0104;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  function automatic logic low_bits_set(input logic [WORD-1:0] addr);
    return (addr[OFFSET_SHIFT-1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: purely combinational next-PC selection.
//   pc          in  32  current PC
//   branch_eq   in  1   beq in flight
//   branch_ne   in  1   bne in flight
//   zero        in  1   ALU zero flag
//   jump        in  1   j/jal in flight
//   jump_reg    in  1   jr in flight
//   immi        in  16  I-type immediate (word offset)
//   target      in  26  J-type target field
//   rs_value    in  32  jr target register value
//   next_pc     out 32  selected next PC (jr > j > taken branch > pc+4)
//   jr_misalign out 1   jr selected with a non-word-aligned register value
module pc_next_calc
  import pc_pkg::*;
(
  input  logic [WORD-1:0] pc,
  input  logic            branch_eq,
  input  logic            branch_ne,
  input  logic            zero,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic [15:0]     immi,
  input  logic [25:0]     target,
  input  logic [WORD-1:0] rs_value,
  output logic [WORD-1:0] next_pc,
  output logic            jr_misalign
);

  logic [WORD-1:0] pc4_s;
  logic [WORD-1:0] br_tgt_s;
  logic [WORD-1:0] j_tgt_s;
  logic [WORD-1:0] jr_tgt_s;
  logic            taken_s;

  // Candidate targets; pc4 wraps silently at the top of the address space.
  always_comb begin
    pc4_s    = pc + 32'd4;
    br_tgt_s = pc4_s + {{14{immi[15]}}, immi, 2'b00};
    j_tgt_s  = {pc4_s[31:28], target, 2'b00};
    jr_tgt_s = {rs_value[31:2], 2'b00};
    taken_s  = (branch_eq & zero) | (branch_ne & ~zero);
  end

  // Priority mux: jr over j over taken branch over sequential.
  always_comb begin
    next_pc     = pc4_s;
    jr_misalign = 1'b0;
    if (jump_reg) begin
      next_pc     = jr_tgt_s;
      jr_misalign = low_bits_set(rs_value);
    end else if (jump) begin
      next_pc = j_tgt_s;
    end else if (taken_s) begin
      next_pc = br_tgt_s;
    end else begin
      next_pc = pc4_s;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC register and BOOT/RUN/HALT sequencing.
//   clk       in  1   rising-edge clock
//   reset     in  1   synchronous active-high reset, dominates everything
//   stall     in  1   hold PC this cycle
//   halt_req  in  1   enter HALT at next edge (beats stall)
//   branch_eq/branch_ne/zero/jump/jump_reg  control and ALU flags
//   immi      in  16  I-type immediate
//   target    in  26  J-type target field
//   rs_value  in  32  jr target
//   PC        out 32  current fetch address
//   pc_valid  out 1   high only in RUN
//   halted    out 1   high in HALT
//   misalign  out 1   sticky: a jr target had nonzero low bits
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [WORD-1:0] HALT_PC  = HALT_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch_eq,
  input  logic            branch_ne,
  input  logic            zero,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic [15:0]     immi,
  input  logic [25:0]     target,
  input  logic [WORD-1:0] rs_value,
  output logic [WORD-1:0] PC,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign
);

  pc_state_e       state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            pc_valid_q, halted_q;
  logic [WORD-1:0] next_pc_s;
  logic            jr_misalign_s;

  pc_next_calc u_next (
    .pc          (pc_q),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .zero        (zero),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .immi        (immi),
    .target      (target),
    .rs_value    (rs_value),
    .next_pc     (next_pc_s),
    .jr_misalign (jr_misalign_s)
  );

  // Next-state logic. The edge that enters HALT does not advance PC, so
  // HALT_PC (or the PC at halt_req) is the value left frozen. Misalign only
  // accumulates on edges where PC actually advances in RUN.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt_req || (pc_q == HALT_PC)) begin
          state_d = HALT;
        end else if (!stall) begin
          pc_d       = next_pc_s;
          misalign_d = misalign_q | jr_misalign_s;
        end else begin
          pc_d = pc_q;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // State, PC and status registers; status flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      pc_valid_q <= (state_d == RUN);
      halted_q   <= (state_d == HALT);
    end
  end

  assign PC       = pc_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign misalign = misalign_q;

endmodule
